// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int unsigned MEM_BYTES         = 65536;
    localparam int unsigned WORD_BYTES        = 4;
    localparam int unsigned DEFAULT_MAX_WORDS = MEM_BYTES / WORD_BYTES;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write port of the loader.
// The master side is the loader itself; the slave side is the stream source plus memory.
interface imem_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words one byte lane at a time.
// word presents the buffer with the strobed byte already merged in.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        strobe,
    input  logic [1:0]  lane,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        complete
);

    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    logic [31:0] buf_q;

    always_comb begin
        word = buf_q;
        if (strobe) begin
            case (lane)
                2'd0:    word[7:0]   = data;
                2'd1:    word[15:8]  = data;
                2'd2:    word[23:16] = data;
                default: word[31:24] = data;
            endcase
        end
    end

    assign complete = strobe && (lane == LAST_LANE);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            buf_q <= '0;
        end else if (strobe) begin
            buf_q <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the CPU while the load is in progress.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    state_t      state;
    logic        in_ready_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic [1:0]  byte_cnt;
    logic [31:0] word_cnt;
    logic [31:0] len;

    logic        accept;
    logic        idle_like;
    logic [31:0] packed_word;
    logic        word_complete;
    logic [31:0] next_word_cnt;

    assign accept        = bus.in_valid && in_ready_q;
    assign idle_like     = (state == IDLE) || (state == DONE) || (state == ERR);
    assign next_word_cnt = word_cnt + 32'd1;

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    // One packer serves both the length field and the data words.
    imem_loader_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (start && idle_like),
        .strobe   (accept),
        .lane     (byte_cnt),
        .data     (bus.in_data),
        .word     (packed_word),
        .complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            len        <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        byte_cnt   <= '0;
                        word_cnt   <= '0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_complete) begin
                            len <= packed_word;
                            if (packed_word == '0) begin
                                state      <= DONE;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                cpu_hold   <= 1'b0;
                                in_ready_q <= 1'b0;
                            end else if (packed_word > MAX_LEN) begin
                                state      <= ERR;
                                error      <= 1'b1;
                                busy       <= 1'b0;
                                cpu_hold   <= 1'b0;
                                in_ready_q <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_complete) begin
                            state      <= WRITE;
                            in_ready_q <= 1'b0;
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= BASE_ADDR + {word_cnt[29:0], 2'b00};
                            wr_data_q  <= packed_word;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= next_word_cnt;
                    if (next_word_cnt == len) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        state      <= DATA;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
